// File: rtl/fir_tap_seq.sv
// fir_tap_seq: tap sequencer and multiply-accumulate engine for an FIR
// filter built on an external 128x8 addressable shift-register delay line
// and an external combinational coefficient store.
//
// Every accepted input sample is shifted into the delay line. The block then
// walks the read address across all NTAPS taps. It multiplies each delayed
// sample by its coefficient, sums the products at full precision, and emits
// one result per sample.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   din, din_valid  signed input sample and its one-cycle strobe
//   sr_d, sr_ce     delay-line write data and shift enable
//   sr_a, sr_y      delay-line read address (0 = newest) and read data
//   coef_a, coef    coefficient address (mirrors sr_a) and coefficient
//   y, y_valid      registered filter result and its one-cycle strobe
//   busy            high while the tap addresses are being walked
//   ovf             sticky overrun flag, cleared only by rst
//   dbg_state       current FSM state (0 = IDLE, 1 = RUN)
//
// Input handshake: there is no ready signal. A sample is taken in any cycle
// where din_valid=1 and rst=0. A sample is clean when it arrives while busy=0
// or in the last RUN cycle (sr_a == NTAPS-1). Any other arrival aborts the
// running sequence, sets ovf and restarts the walk at sr_a=0.
module fir_tap_seq #(
  parameter int NTAPS = 128,
  parameter int CW    = 10,
  parameter int AW    = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [7:0]    din,
  input  logic                 din_valid,
  output logic [7:0]           sr_d,
  output logic                 sr_ce,
  output logic [6:0]           sr_a,
  input  logic signed [7:0]    sr_y,
  output logic [6:0]           coef_a,
  input  logic signed [CW-1:0] coef,
  output logic signed [AW-1:0] y,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 ovf,
  output logic                 dbg_state
);

  localparam int         PW     = 8 + CW;
  localparam logic [6:0] LAST_A = 7'(NTAPS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state;

  // Pipeline: S1 holds the operands, S2 the product, S3 the accumulator.
  logic                 s1_v, s1_first, s1_last;
  logic signed [7:0]    s1_x;
  logic signed [CW-1:0] s1_c;
  logic                 s2_v, s2_first, s2_last;
  logic signed [PW-1:0] s2_p;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] p_ext;
  logic                 last_addr;

  // The delay line reads the pre-shift value, so it can be written while it
  // is read.
  assign sr_d      = din;
  assign sr_ce     = din_valid & ~rst;
  assign coef_a    = sr_a;
  assign dbg_state = state;
  assign last_addr = (sr_a == LAST_A);
  assign p_ext     = AW'(s2_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr_a     <= 7'd0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_c     <= '0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
      acc      <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            state <= RUN;
            busy  <= 1'b1;
            sr_a  <= 7'd0;
          end
        end
        RUN: begin
          if (din_valid) begin
            // A restart in the last address is a clean back-to-back sample.
            // A restart anywhere else is an overrun. The aborted entries
            // still in flight carry no last tag, and the new first tag
            // overwrites their partial sum.
            sr_a <= 7'd0;
            if (!last_addr) ovf <= 1'b1;
          end else if (last_addr) begin
            state <= IDLE;
            busy  <= 1'b0;
            sr_a  <= 7'd0;
          end else begin
            sr_a <= sr_a + 7'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sr_a  <= 7'd0;
        end
      endcase

      // S1: capture the operands for the address presented this cycle.
      s1_v     <= (state == RUN);
      s1_first <= (state == RUN) && (sr_a == 7'd0);
      s1_last  <= (state == RUN) && last_addr;
      s1_x     <= sr_y;
      s1_c     <= coef;

      // S2: full-precision signed product.
      s2_v     <= s1_v;
      s2_first <= s1_v & s1_first;
      s2_last  <= s1_v & s1_last;
      s2_p     <= PW'(s1_x) * PW'(s1_c);

      // S3: accumulate. The result is formed directly from acc + product so
      // acc is free for the next sequence's first tag one cycle later.
      y_valid <= 1'b0;
      if (s2_v) begin
        if (s2_first) acc <= p_ext;
        else          acc <= acc + p_ext;
        if (s2_last) begin
          y       <= acc + p_ext;
          y_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_seq.sv
module tb_fir_tap_seq;
  localparam int CW = 10;
  localparam int AW = 25;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- long filter (NTAPS=128) ----------------
  logic                 rst_l = 1'b1;
  logic signed [7:0]    din_l = '0;
  logic                 dv_l  = 1'b0;
  logic [7:0]           sr_d_l;
  logic                 sr_ce_l;
  logic [6:0]           sr_a_l;
  logic signed [7:0]    sr_y_l;
  logic [6:0]           coef_a_l;
  logic signed [CW-1:0] coef_l;
  logic signed [AW-1:0] y_l;
  logic                 yv_l, busy_l, ovf_l, dbg_l;
  logic [7:0]           dl_l [128] = '{default: 8'h00};
  logic signed [CW-1:0] cm_l [128];

  always @(posedge clk) if (sr_ce_l) begin
    for (int i = 127; i > 0; i--) dl_l[i] <= dl_l[i-1];
    dl_l[0] <= sr_d_l;
  end
  assign sr_y_l = dl_l[sr_a_l];
  assign coef_l = cm_l[coef_a_l];

  fir_tap_seq #(.NTAPS(128), .CW(CW), .AW(AW)) dut_l (
    .clk(clk), .rst(rst_l), .din(din_l), .din_valid(dv_l),
    .sr_d(sr_d_l), .sr_ce(sr_ce_l), .sr_a(sr_a_l), .sr_y(sr_y_l),
    .coef_a(coef_a_l), .coef(coef_l), .y(y_l), .y_valid(yv_l),
    .busy(busy_l), .ovf(ovf_l), .dbg_state(dbg_l)
  );

  // ---------------- short filter (NTAPS=4) ----------------
  logic                 rst_s = 1'b1;
  logic signed [7:0]    din_s = '0;
  logic                 dv_s  = 1'b0;
  logic [7:0]           sr_d_s;
  logic                 sr_ce_s;
  logic [6:0]           sr_a_s;
  logic signed [7:0]    sr_y_s;
  logic [6:0]           coef_a_s;
  logic signed [CW-1:0] coef_s;
  logic signed [AW-1:0] y_s;
  logic                 yv_s, busy_s, ovf_s, dbg_s;
  logic [7:0]           dl_s [128] = '{default: 8'h00};
  logic signed [CW-1:0] cm_s [128];

  always @(posedge clk) if (sr_ce_s) begin
    for (int i = 127; i > 0; i--) dl_s[i] <= dl_s[i-1];
    dl_s[0] <= sr_d_s;
  end
  assign sr_y_s = dl_s[sr_a_s];
  assign coef_s = cm_s[coef_a_s];

  fir_tap_seq #(.NTAPS(4), .CW(CW), .AW(AW)) dut_s (
    .clk(clk), .rst(rst_s), .din(din_s), .din_valid(dv_s),
    .sr_d(sr_d_s), .sr_ce(sr_ce_s), .sr_a(sr_a_s), .sr_y(sr_y_s),
    .coef_a(coef_a_s), .coef(coef_s), .y(y_s), .y_valid(yv_s),
    .busy(busy_s), .ovf(ovf_s), .dbg_state(dbg_s)
  );

  // ---------------- reference model + scoreboard ----------------
  logic signed [7:0]    hist_l[$];
  logic signed [7:0]    hist_s[$];
  logic signed [AW-1:0] exp_q_l[$];
  logic signed [AW-1:0] exp_q_s[$];
  int                   expt_q_l[$];
  int                   expt_q_s[$];
  logic signed [AW-1:0] obs_l[$];
  logic signed [AW-1:0] obs_s[$];
  int                   run_end_l = 0;
  int                   run_end_s = 0;
  bit                   ovf_exp_l = 1'b0;

  function automatic logic signed [AW-1:0] dot_l();
    longint s = 0;
    for (int k = 0; k < 128; k++) s += longint'(hist_l[k]) * longint'(cm_l[k]);
    return AW'(s);
  endfunction

  function automatic logic signed [AW-1:0] dot_s();
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(hist_s[k]) * longint'(cm_s[k]);
    return AW'(s);
  endfunction

  // Advance to the next falling edge and score any result strobes.
  task automatic step();
    logic signed [AW-1:0] e;
    int et;
    @(negedge clk);
    while (expt_q_l.size() > 0 && expt_q_l[0] < cyc) begin
      checks++; failures++;
      $display("FAIL y_l_missing cyc=%0d required y=%0d at cyc=%0d", cyc, exp_q_l[0], expt_q_l[0]);
      void'(exp_q_l.pop_front()); void'(expt_q_l.pop_front());
    end
    while (expt_q_s.size() > 0 && expt_q_s[0] < cyc) begin
      checks++; failures++;
      $display("FAIL y_s_missing cyc=%0d required y=%0d at cyc=%0d", cyc, exp_q_s[0], expt_q_s[0]);
      void'(exp_q_s.pop_front()); void'(expt_q_s.pop_front());
    end
    if (yv_l) begin
      checks++;
      obs_l.push_back(y_l);
      if (exp_q_l.size() == 0) begin
        failures++;
        $display("FAIL y_l_unexpected cyc=%0d y=%0d required no y_valid", cyc, y_l);
      end else begin
        e = exp_q_l.pop_front(); et = expt_q_l.pop_front();
        if (y_l !== e || cyc != et) begin
          failures++;
          $display("FAIL y_l cyc=%0d y=%0d required y=%0d at cyc=%0d", cyc, y_l, e, et);
        end
      end
    end
    if (yv_s) begin
      checks++;
      obs_s.push_back(y_s);
      if (exp_q_s.size() == 0) begin
        failures++;
        $display("FAIL y_s_unexpected cyc=%0d y=%0d required no y_valid", cyc, y_s);
      end else begin
        e = exp_q_s.pop_front(); et = expt_q_s.pop_front();
        if (y_s !== e || cyc != et) begin
          failures++;
          $display("FAIL y_s cyc=%0d y=%0d required y=%0d at cyc=%0d", cyc, y_s, e, et);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one sample for one cycle (called on a falling edge).
  task automatic send_l(input logic signed [7:0] d);
    if (cyc < run_end_l) begin
      // Arrival inside the walk but before the last tap: running result is lost.
      ovf_exp_l = 1'b1;
      if (exp_q_l.size() > 0) begin
        void'(exp_q_l.pop_back()); void'(expt_q_l.pop_back());
      end
    end
    hist_l.push_front(d); void'(hist_l.pop_back());
    exp_q_l.push_back(dot_l());
    expt_q_l.push_back(cyc + 128 + 3);
    run_end_l = cyc + 128;
    din_l = d; dv_l = 1'b1;
    step();
    dv_l = 1'b0;
  endtask

  task automatic send_s(input logic signed [7:0] d);
    hist_s.push_front(d); void'(hist_s.pop_back());
    exp_q_s.push_back(dot_s());
    expt_q_s.push_back(cyc + 4 + 3);
    run_end_s = cyc + 4;
    din_s = d; dv_s = 1'b1;
    step();
    dv_s = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q_l.size() > 0 || exp_q_s.size() > 0) && b < 400) begin
      step(); b++;
    end
    checks++;
    if (exp_q_l.size() > 0 || exp_q_s.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending_l=%0d pending_s=%0d required 0", exp_q_l.size(), exp_q_s.size());
    end
    repeat (6) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 128; k++) begin cm_l[k] = '0; cm_s[k] = '0; end
    rst_l = 1'b1; rst_s = 1'b1;
    repeat (3) step();
    din_l = 8'sd55; dv_l = 1'b1;
    #1;
    checks++;
    if (sr_ce_l !== 1'b0) begin failures++; $display("FAIL reset_sr_ce got=%b required 0", sr_ce_l); end
    step();
    dv_l = 1'b0;
    checks++;
    if (busy_l !== 1'b0 || sr_a_l !== 7'd0 || y_l !== '0 || yv_l !== 1'b0 || ovf_l !== 1'b0 || dbg_l !== 1'b0) begin
      failures++;
      $display("FAIL reset_l busy=%b sr_a=%0d y=%0d yv=%b ovf=%b dbg=%b required all 0", busy_l, sr_a_l, y_l, yv_l, ovf_l, dbg_l);
    end
    checks++;
    if (busy_s !== 1'b0 || sr_a_s !== 7'd0 || y_s !== '0 || yv_s !== 1'b0 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_s busy=%b sr_a=%0d y=%0d yv=%b ovf=%b required all 0", busy_s, sr_a_s, y_s, yv_s, ovf_s);
    end
    rst_l = 1'b0; rst_s = 1'b0;
    step();
  endtask

  task automatic test_impulse();
    int n0;
    for (int k = 0; k < 128; k++) cm_l[k] = CW'(k + 1);
    n0 = obs_l.size();
    din_l = 8'sd1; dv_l = 1'b1;
    #1;
    checks++;
    if (sr_ce_l !== 1'b1 || sr_d_l !== 8'd1) begin
      failures++; $display("FAIL impulse_sr_ce sr_ce=%b sr_d=%0d required 1,1", sr_ce_l, sr_d_l);
    end
    send_l(8'sd1);
    for (int i = 0; i < 128; i++) begin
      repeat (127) step();
      send_l(8'sd0);
    end
    drain();
    checks++;
    if (obs_l.size() - n0 != 129) begin
      failures++; $display("FAIL impulse_count got=%0d required 129", obs_l.size() - n0);
    end else begin
      for (int i = 0; i < 129; i++) begin
        checks++;
        if (obs_l[n0 + i] !== ((i < 128) ? AW'(i + 1) : AW'(0))) begin
          failures++;
          $display("FAIL impulse_y idx=%0d got=%0d required %0d", i, obs_l[n0 + i], (i < 128) ? i + 1 : 0);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic signed [AW-1:0] want_pos, want_neg;
    want_pos = 25'sd8388608;
    want_neg = -25'sd8323072;
    for (int k = 0; k < 128; k++) cm_l[k] = -10'sd512;
    send_l(-8'sd128);
    for (int i = 1; i < 128; i++) begin repeat (127) step(); send_l(-8'sd128); end
    drain();
    checks++;
    if (obs_l[obs_l.size() - 1] !== want_pos) begin
      failures++; $display("FAIL extreme_pos got=%0d required %0d", obs_l[obs_l.size() - 1], want_pos);
    end
    send_l(8'sd127);
    for (int i = 1; i < 128; i++) begin repeat (127) step(); send_l(8'sd127); end
    drain();
    checks++;
    if (obs_l[obs_l.size() - 1] !== want_neg) begin
      failures++; $display("FAIL extreme_neg got=%0d required %0d", obs_l[obs_l.size() - 1], want_neg);
    end
  endtask

  task automatic test_full_rate();
    int lows = 0;
    int n0;
    for (int k = 0; k < 128; k++) cm_l[k] = CW'($urandom_range(0, 1023));
    n0 = obs_l.size();
    send_l(8'($urandom_range(0, 255)));
    lows += (busy_l !== 1'b1);
    for (int i = 1; i < 10; i++) begin
      repeat (127) begin step(); lows += (busy_l !== 1'b1); end
      send_l(8'($urandom_range(0, 255)));
      lows += (busy_l !== 1'b1);
    end
    repeat (127) begin step(); lows += (busy_l !== 1'b1); end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL full_rate_busy low_cycles=%0d required 0", lows); end
    checks++;
    if (ovf_l !== 1'b0) begin failures++; $display("FAIL full_rate_ovf got=%b required 0", ovf_l); end
    drain();
    checks++;
    if (obs_l.size() - n0 != 10) begin
      failures++; $display("FAIL full_rate_count got=%0d required 10", obs_l.size() - n0);
    end
  endtask

  task automatic test_overrun();
    int n0;
    n0 = obs_l.size();
    send_l(8'sd37);
    repeat (49) step();
    checks++;
    if (ovf_l !== 1'b0) begin failures++; $display("FAIL overrun_pre_ovf got=%b required 0", ovf_l); end
    send_l(-8'sd91);
    checks++;
    if (ovf_l !== 1'b1 || ovf_exp_l !== 1'b1) begin
      failures++; $display("FAIL overrun_ovf got=%b required 1", ovf_l);
    end
    drain();
    checks++;
    if (ovf_l !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b required 1", ovf_l); end
    checks++;
    if (obs_l.size() - n0 != 1) begin
      failures++; $display("FAIL overrun_count got=%0d required 1", obs_l.size() - n0);
    end
  endtask

  task automatic test_reset_mid_run();
    send_l(8'sd73);
    repeat (59) step();
    rst_l = 1'b1; din_l = 8'sd99; dv_l = 1'b1;
    #1;
    checks++;
    if (sr_ce_l !== 1'b0) begin failures++; $display("FAIL rst_mid_sr_ce got=%b required 0", sr_ce_l); end
    exp_q_l.delete(); expt_q_l.delete();
    run_end_l = 0; ovf_exp_l = 1'b0;
    step();
    rst_l = 1'b0; dv_l = 1'b0;
    checks++;
    if (busy_l !== 1'b0 || sr_a_l !== 7'd0 || y_l !== '0 || ovf_l !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid busy=%b sr_a=%0d y=%0d ovf=%b required 0,0,0,0", busy_l, sr_a_l, y_l, ovf_l);
    end
    repeat (200) step();
    send_l(-8'sd5);
    drain();
  endtask

  task automatic test_random();
    int gap;
    int r;
    for (int k = 0; k < 128; k++) cm_l[k] = CW'($urandom_range(0, 1023));
    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      gap = (r < 2) ? $urandom_range(20, 127) : (r < 7) ? 128 : $urandom_range(129, 200);
      send_l(8'($urandom_range(0, 255)));
      repeat (gap - 1) step();
    end
    drain();
    checks++;
    if (ovf_l !== ovf_exp_l) begin
      failures++; $display("FAIL random_ovf got=%b required %b", ovf_l, ovf_exp_l);
    end
  endtask

  task automatic test_short();
    int n0;
    for (int k = 0; k < 128; k++) cm_s[k] = 10'sd1;
    n0 = obs_s.size();
    send_s(8'sd1); repeat (3) step();
    send_s(8'sd2); repeat (3) step();
    send_s(8'sd3); repeat (3) step();
    send_s(8'sd4);
    drain();
    checks++;
    if (obs_s.size() - n0 != 4) begin
      failures++; $display("FAIL short_count got=%0d required 4", obs_s.size() - n0);
    end else begin
      checks++;
      if (obs_s[n0] !== 25'sd1 || obs_s[n0+1] !== 25'sd3 || obs_s[n0+2] !== 25'sd6 || obs_s[n0+3] !== 25'sd10) begin
        failures++;
        $display("FAIL short_y got=%0d,%0d,%0d,%0d required 1,3,6,10", obs_s[n0], obs_s[n0+1], obs_s[n0+2], obs_s[n0+3]);
      end
    end
    checks++;
    if (ovf_s !== 1'b0) begin failures++; $display("FAIL short_ovf got=%b required 0", ovf_s); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int k = 0; k < 128; k++) hist_l.push_back(8'sd0);
    for (int k = 0; k < 4; k++) hist_s.push_back(8'sd0);
    test_reset();
    test_impulse();
    test_extremes();
    test_full_rate();
    test_overrun();
    test_reset_mid_run();
    test_random();
    test_short();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
